pdua_control_unit: RTL
======================

# pdua_control_unit

Hardwired multi-cycle control unit for the 8-bit PDUA datapath. It consumes the 5-bit opcode from the datapath's instruction register and the ALU flags C/N/P/Z. Every cycle it drives the full control word: ALU select and flag enable, register-bank read/write addresses and write enable, IR/MAR/MDR enables, MDR source select and memory read/write. It implements fetch, decode and execute for ALU, load, store, conditional-jump, NOP and HALT instructions.

## Interface
- ADDR_WIDTH, 3, register-bank address width
- PC_ADDR, 3'b111, bank address of the program counter
- ACC_ADDR, 3'b110, bank address of the accumulator
- MDR_ADDR, 3'b000, bus-B address that selects the MDR onto bus B
- SEL_PASS, 3'b000, selop code: ALU output = bus B
- SEL_INC, 3'b001, selop code: ALU output = bus B + 1
- clk  in  1  system clock, all state changes on rising edge
- rst  in  1  synchronous, active-low reset
- opcode  in  5  IR contents (out_IR of datapath)
- C, N, P, Z  in  1 each  ALU flags from datapath
- wr_rdn  out  1  memory write (1) / read (0)
- enaf  out  1  ALU flag-register update enable
- selop  out  3  ALU operation select
- shamt  out  2  shift amount
- bank_wr_en  out  1  register-bank write enable (bus C)
- BusB_addr  out  ADDR_WIDTH  bank read address onto bus B
- BusC_addr  out  ADDR_WIDTH  bank write address from bus C
- sclr  out  1  synchronous clear of datapath registers
- ir_en, mar_en, mdr_en  out  1 each  register load enables
- mdr_alu_n  out  1  MDR source: 1 = ALU output, 0 = memory data
- halted  out  1  high while in HALT
- instr_done  out  1  one-cycle pulse in the last cycle of every instruction

## Operation
- Moore FSM. All outputs decode from the state register and the latched opcode. Any output not listed for a state is 0, with BusB_addr = BusC_addr = 0, selop = SEL_PASS and shamt = 0.
- Opcode classes: op[4:3]=00 ALU, 01 memory (op[2]=0 load, op[2]=1 store), 10 jump (op[1:0]: 00 always, 01 Z, 10 N, 11 C), 11 NOP, except 5'b11111 = HALT.
- States and control words:
  - RST: sclr=1. Leaves to F0.
  - F0: BusB=PC, SEL_PASS, mar_en.
  - F1: mdr_en, mdr_alu_n=0, wr_rdn=0. Same cycle: BusB=PC, SEL_INC, BusC=PC, bank_wr_en.
  - F2: ir_en.
  - DEC: idle. Branches on opcode.
- ALU class:
  - E0: BusB=ACC, selop=op[2:0], shamt=2'b01, BusC=ACC, bank_wr_en, enaf, instr_done. Leaves to F0.
- Load/store:
  - M0: as F0.
  - M1: as F1 (operand address fetched, PC advanced).
  - M2: BusB=MDR_ADDR, SEL_PASS, mar_en.
  - Load: L3 mdr_en, mdr_alu_n=0. Then L4: BusB=MDR_ADDR, SEL_PASS, BusC=ACC, bank_wr_en, enaf, instr_done.
  - Store: S3 BusB=ACC, SEL_PASS, mdr_en, mdr_alu_n=1. Then S4: wr_rdn=1, instr_done.
- Jump:
  - J0: as F0.
  - J1: as F1.
  - J2: BusB=MDR_ADDR, SEL_PASS, BusC=PC, bank_wr_en = taken, instr_done.
  - taken = always, Z, N or C per op[1:0], sampled in J2. Flags cannot change during a jump because enaf=0 throughout.
- NOP: N0 with instr_done only, then F0.
- HALT: halted=1, all control outputs idle. Stays in HALT until reset.
- P flag is ignored by the jump decode. It is an input only for completeness.

## Timing
- rst low at a rising edge puts the FSM in RST on that edge, regardless of current state, including mid-instruction. Outputs are then sclr=1 and everything else 0 (halted=0, instr_done=0).
- The first edge with rst high moves RST to F0.
- Cycles per instruction, counted from F0 through to the instr_done cycle inclusive:
  - ALU 5
  - NOP 5
  - jump 7
  - load 9
  - store 9
- The next instruction's F0 is the cycle after instr_done.
- The opcode input is sampled only in DEC and is latched internally there. Later IR changes do not affect the instruction in flight.
- wr_rdn=1 occurs only in S4, exactly one cycle. It is never asserted together with mdr_en.
- bank_wr_en is never asserted with BusC_addr other than PC_ADDR or ACC_ADDR.

## Test plan
- Reset: hold rst=0 for 2 cycles, release.
  - Expect sclr=1 during and one cycle after release, then the F0 word (BusB=3'b111, mar_en=1). halted=0.
- ALU: opcode=5'b00101 at DEC.
  - Expect E0: selop=3'b101, shamt=2'b01, enaf=1, BusB=BusC=3'b110, bank_wr_en=1, instr_done=1 in cycle 5, then F0.
- Load/store: opcode=5'b01000, then 5'b01100.
  - Load: instr_done in cycle 9 with BusC=3'b110 and enaf=1.
  - Store: wr_rdn=1 only in cycle 9, and S3 has mdr_alu_n=1, mdr_en=1.
- Jump: opcode=5'b10001 with Z=1, then Z=0.
  - Z=1: J2 has bank_wr_en=1, BusC=3'b111.
  - Z=0: J2 has bank_wr_en=0. Both take 7 cycles.
- HALT and reset mid-instruction:
  - opcode=5'b11111: halted=1 for 20 cycles with all controls 0.
  - rst=0 during L3 of a load: next cycle is RST (sclr=1, wr_rdn=0, mdr_en=0).

Source files
------------

// File: rtl/pdua_control_unit.sv
// Hardwired multi-cycle control unit for the 8-bit PDUA datapath.
// A Moore FSM that sequences fetch, decode and execute and drives the
// complete datapath control word each cycle from the state and latched opcode.
module pdua_control_unit #(
  parameter int                    ADDR_WIDTH = 3,
  parameter logic [ADDR_WIDTH-1:0] PC_ADDR    = 3'b111,
  parameter logic [ADDR_WIDTH-1:0] ACC_ADDR   = 3'b110,
  parameter logic [ADDR_WIDTH-1:0] MDR_ADDR   = 3'b000,
  parameter logic [2:0]            SEL_PASS   = 3'b000,
  parameter logic [2:0]            SEL_INC    = 3'b001
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4:0]            opcode,
  input  logic                  C,
  input  logic                  N,
  input  logic                  P,
  input  logic                  Z,
  output logic                  wr_rdn,
  output logic                  enaf,
  output logic [2:0]            selop,
  output logic [1:0]            shamt,
  output logic                  bank_wr_en,
  output logic [ADDR_WIDTH-1:0] BusB_addr,
  output logic [ADDR_WIDTH-1:0] BusC_addr,
  output logic                  sclr,
  output logic                  ir_en,
  output logic                  mar_en,
  output logic                  mdr_en,
  output logic                  mdr_alu_n,
  output logic                  halted,
  output logic                  instr_done
);

  typedef enum logic [4:0] {
    ST_RST, ST_F0, ST_F1, ST_F2, ST_DEC,
    ST_E0,
    ST_M0, ST_M1, ST_M2, ST_L3, ST_L4, ST_S3, ST_S4,
    ST_J0, ST_J1, ST_J2,
    ST_N0, ST_HALT
  } state_t;

  state_t     r_state;
  state_t     w_next;
  // Only the low opcode bits matter after decode: ALU op, load/store, jump cond.
  logic [2:0] r_op;
  logic       w_taken;
  // The P flag plays no part in jump decode; kept as a port for the datapath.
  logic       w_unused_p;

  assign w_unused_p = P;

  // Jump condition from the latched opcode; flags are stable because enaf=0.
  always_comb begin
    case (r_op[1:0])
      2'b00:   w_taken = 1'b1;
      2'b01:   w_taken = Z;
      2'b10:   w_taken = N;
      default: w_taken = C;
    endcase
  end

  // State register and opcode latch; reset wins over any state.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_RST;
      r_op    <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_DEC) r_op <= opcode[2:0];
    end
  end

  // Next-state and control-word decode.
  // NOTE: every output and w_next gets a default first, so no path through
  // the case can leave a value unassigned and infer a latch.
  always_comb begin
    w_next     = r_state;
    wr_rdn     = 1'b0;
    enaf       = 1'b0;
    selop      = SEL_PASS;
    shamt      = 2'b00;
    bank_wr_en = 1'b0;
    BusB_addr  = '0;
    BusC_addr  = '0;
    sclr       = 1'b0;
    ir_en      = 1'b0;
    mar_en     = 1'b0;
    mdr_en     = 1'b0;
    mdr_alu_n  = 1'b0;
    halted     = 1'b0;
    instr_done = 1'b0;

    case (r_state)
      ST_RST: begin
        sclr   = 1'b1;
        w_next = ST_F0;
      end
      // PC -> MAR: instruction or operand address.
      ST_F0, ST_M0, ST_J0: begin
        BusB_addr = PC_ADDR;
        mar_en    = 1'b1;
        w_next    = (r_state == ST_F0) ? ST_F1 :
                    (r_state == ST_M0) ? ST_M1 : ST_J1;
      end
      // Memory read into MDR while PC advances.
      ST_F1, ST_M1, ST_J1: begin
        mdr_en     = 1'b1;
        BusB_addr  = PC_ADDR;
        selop      = SEL_INC;
        BusC_addr  = PC_ADDR;
        bank_wr_en = 1'b1;
        w_next     = (r_state == ST_F1) ? ST_F2 :
                     (r_state == ST_M1) ? ST_M2 : ST_J2;
      end
      ST_F2: begin
        ir_en  = 1'b1;
        w_next = ST_DEC;
      end
      ST_DEC: begin
        case (opcode[4:3])
          2'b00:   w_next = ST_E0;
          2'b01:   w_next = ST_M0;
          2'b10:   w_next = ST_J0;
          default: w_next = (opcode == 5'b11111) ? ST_HALT : ST_N0;
        endcase
      end
      ST_E0: begin
        BusB_addr  = ACC_ADDR;
        selop      = r_op;
        shamt      = 2'b01;
        BusC_addr  = ACC_ADDR;
        bank_wr_en = 1'b1;
        enaf       = 1'b1;
        instr_done = 1'b1;
        w_next     = ST_F0;
      end
      // Operand address (now in MDR) -> MAR.
      ST_M2: begin
        BusB_addr = MDR_ADDR;
        mar_en    = 1'b1;
        w_next    = r_op[2] ? ST_S3 : ST_L3;
      end
      ST_L3: begin
        mdr_en = 1'b1;
        w_next = ST_L4;
      end
      ST_L4: begin
        BusB_addr  = MDR_ADDR;
        BusC_addr  = ACC_ADDR;
        bank_wr_en = 1'b1;
        enaf       = 1'b1;
        instr_done = 1'b1;
        w_next     = ST_F0;
      end
      ST_S3: begin
        BusB_addr = ACC_ADDR;
        mdr_en    = 1'b1;
        mdr_alu_n = 1'b1;
        w_next    = ST_S4;
      end
      ST_S4: begin
        wr_rdn     = 1'b1;
        instr_done = 1'b1;
        w_next     = ST_F0;
      end
      // Target address (in MDR) -> PC only when the condition holds.
      ST_J2: begin
        BusB_addr  = MDR_ADDR;
        BusC_addr  = PC_ADDR;
        bank_wr_en = w_taken;
        instr_done = 1'b1;
        w_next     = ST_F0;
      end
      ST_N0: begin
        instr_done = 1'b1;
        w_next     = ST_F0;
      end
      ST_HALT: begin
        halted = 1'b1;
      end
      default: w_next = ST_RST;
    endcase
  end

endmodule
